// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the MIPS32 fetch/data requesters, the memory arbiter and the unified memory.
// master: arbiter side. slave: requesters plus memory side.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter: MEM-stage data port has priority over IF-stage fetch, one access in flight.
// Define MIPS_ARB_STARVE_EN to add the fetch anti-starvation counter (forces fetch after STARVE_MAX losses).
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk1,
  input  logic                 rst,
  mips32_mem_arbiter_if.master bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mips32_mem_arbiter: MEM_LAT must be 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
    $error("mips32_mem_arbiter: STARVE_MAX must be 1..7");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 2);

  state_e        state_q;
  logic          sel_d_q;
  logic          op_we_q;
  logic [3:0]    wait_q;
  logic          if_gnt_q;
  logic          d_gnt_q;
  logic          if_valid_q;
  logic          d_valid_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          arb_s;
  logic          win_dp_s;
  logic          win_if_s;
  logic          resp_s;
  logic          starve_hit_s;

`ifdef MIPS_ARB_STARVE_EN
  logic [2:0] starve_q;
  logic [2:0] starve_d;

  assign starve_hit_s = (starve_q == 3'(STARVE_MAX));

  // Count arbitrations fetch loses to data while both request; any fetch win clears it.
  always_comb begin
    starve_d = starve_q;
    if (arb_s && win_if_s) begin
      starve_d = 3'd0;
    end else if (arb_s && win_dp_s && bus.if_req && !starve_hit_s) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  assign arb_s  = (state_q == IDLE) || (state_q == RESP);
  assign resp_s = ((state_q == ISSUE) && (MEM_LAT == 1)) ||
                  ((state_q == WAIT) && (wait_q == 4'd0));

  // Winner selection from the request levels seen this cycle.
  always_comb begin
    win_dp_s = 1'b0;
    win_if_s = 1'b0;
    if (bus.d_req && !(bus.if_req && starve_hit_s)) begin
      win_dp_s = 1'b1;
    end else if (bus.if_req) begin
      win_if_s = 1'b1;
    end else begin
      win_dp_s = 1'b0;
      win_if_s = 1'b0;
    end
  end

  // Sequencer with registered handshake and memory strobes.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_d_q     <= 1'b0;
      op_we_q     <= 1'b0;
      wait_q      <= 4'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;

      case (state_q)
        IDLE, RESP: begin
          if (win_dp_s) begin
            state_q     <= ISSUE;
            sel_d_q     <= 1'b1;
            op_we_q     <= bus.d_we;
            d_gnt_q     <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (win_if_s) begin
            state_q    <= ISSUE;
            sel_d_q    <= 1'b0;
            op_we_q    <= 1'b0;
            if_gnt_q   <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_addr_q <= bus.if_addr;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 1) begin
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
            wait_q  <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Completion: stores pulse d_valid but leave the load data register untouched.
      if (resp_s) begin
        if (sel_d_q) begin
          d_valid_q <= 1'b1;
          if (!op_we_q) begin
            d_rdata_q <= bus.mem_rdata;
          end
        end else begin
          if_valid_q <= 1'b1;
          if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: three instances with MEM_LAT 1, 2, 3, each with its own memory model.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NI = 3;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst_s, if_req_s, d_req_s, d_we_s;
  logic [AW-1:0] if_addr_s [NI];
  logic [AW-1:0] d_addr_s  [NI];
  logic [DW-1:0] d_wdata_s [NI];
  logic [NI-1:0] if_gnt_s, if_valid_s, d_gnt_s, d_valid_s, mem_en_s, mem_we_s;
  logic [DW-1:0] if_rdata_s  [NI];
  logic [DW-1:0] d_rdata_s   [NI];
  logic [AW-1:0] mem_addr_s  [NI];
  logic [DW-1:0] mem_wdata_s [NI];

  function automatic logic [DW-1:0] init_word(int a);
    if (a == 0) return 32'h28010080;
    return 32'hA5000000 ^ (32'(a) * 32'h00010003);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : lat
    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    logic [DW-1:0] mem_arr [0:1023];

    assign bus.if_req  = if_req_s[g];
    assign bus.if_addr = if_addr_s[g];
    assign bus.d_req   = d_req_s[g];
    assign bus.d_we    = d_we_s[g];
    assign bus.d_addr  = d_addr_s[g];
    assign bus.d_wdata = d_wdata_s[g];
    assign if_gnt_s[g]    = bus.if_gnt;
    assign if_valid_s[g]  = bus.if_valid;
    assign if_rdata_s[g]  = bus.if_rdata;
    assign d_gnt_s[g]     = bus.d_gnt;
    assign d_valid_s[g]   = bus.d_valid;
    assign d_rdata_s[g]   = bus.d_rdata;
    assign mem_en_s[g]    = bus.mem_en;
    assign mem_we_s[g]    = bus.mem_we;
    assign mem_addr_s[g]  = bus.mem_addr;
    assign mem_wdata_s[g] = bus.mem_wdata;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(g + 1), .STARVE_MAX(STARVE_MAX)) dut (
      .clk1(clk),
      .rst (rst_s[g]),
      .bus (bus.master)
    );

    initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
    end

    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end

    if (g == 0) begin : comb_rd
      assign bus.mem_rdata = mem_arr[bus.mem_addr];
    end else begin : reg_rd
      logic [DW-1:0] pipe [0:g-1];
      always @(posedge clk) begin
        pipe[0] <= mem_arr[bus.mem_addr];
        for (int j = 1; j < g; j++) pipe[j] <= pipe[j-1];
      end
      assign bus.mem_rdata = pipe[g-1];
    end
  end

  typedef struct {
    int            inst;
    bit            is_d;
    logic [DW-1:0] data;
    int            cycle;
  } exp_t;

  typedef struct {
    int            inst;
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  exp_t          sb_q [$];
  logic [DW-1:0] last_d [NI];
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void mon_take(int g, bit is_d, logic [DW-1:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_valid", {32'(g), 31'd0, is_d}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check("valid_inst", 64'(g), 64'(e.inst));
      check("valid_port", 64'(is_d), 64'(e.is_d));
      check("valid_rdata", 64'(data), 64'(e.data));
      check("valid_cycle", 64'(cyc), 64'(e.cycle));
    end
  endfunction

  // Response monitor: every valid pulse must match the scoreboard head.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (if_valid_s[g]) mon_take(g, 1'b0, if_rdata_s[g]);
      if (d_valid_s[g])  mon_take(g, 1'b1, d_rdata_s[g]);
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic push_exp(int inst, bit is_d, logic [DW-1:0] data, int cycle);
    exp_t e;
    e.inst = inst; e.is_d = is_d; e.data = data; e.cycle = cycle;
    sb_q.push_back(e);
  endtask

  task automatic do_access(vec_t v);
    int c;
    bit got;
    @(negedge clk);
    if (v.is_d) begin
      d_req_s[v.inst] = 1'b1; d_we_s[v.inst] = v.we;
      d_addr_s[v.inst] = v.addr; d_wdata_s[v.inst] = v.wdata;
    end else begin
      if_req_s[v.inst] = 1'b1; if_addr_s[v.inst] = v.addr;
    end
    c = cyc;
    push_exp(v.inst, v.is_d, (v.is_d && v.we) ? last_d[v.inst] : v.rdata, c + 1 + (v.inst + 1));
    if (v.is_d && !v.we) last_d[v.inst] = v.rdata;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = v.is_d ? d_gnt_s[v.inst] : if_gnt_s[v.inst];
    end
    check("gnt_seen", 64'(got), 64'd1);
    check("gnt_cycle", 64'(cyc), 64'(c + 1));
    check("mem_en", 64'(mem_en_s[v.inst]), 64'd1);
    check("mem_we", 64'(mem_we_s[v.inst]), 64'(v.is_d && v.we));
    check("mem_addr", 64'(mem_addr_s[v.inst]), 64'(v.addr));
    if (v.is_d && v.we) check("mem_wdata", 64'(mem_wdata_s[v.inst]), 64'(v.wdata));
    check("other_gnt", 64'(v.is_d ? if_gnt_s[v.inst] : d_gnt_s[v.inst]), 64'd0);
    if_req_s[v.inst] = 1'b0;
    d_req_s[v.inst]  = 1'b0;
    wait_drain();
  endtask

  task automatic wait_gnt(int inst, output bit got);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = if_gnt_s[inst] | d_gnt_s[inst];
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    int   c, prev, k_model;
    bit   got, exp_if;

    vecs[0] = '{0, 1'b0, 1'b0, 10'd0,    32'd0,          32'h28010080};
    vecs[1] = '{1, 1'b1, 1'b1, 10'd129,  32'd150,        32'd0};
    vecs[2] = '{1, 1'b1, 1'b0, 10'd129,  32'd0,          32'd150};
    vecs[3] = '{0, 1'b1, 1'b0, 10'd1023, 32'd0,          init_word(1023)};
    vecs[4] = '{2, 1'b1, 1'b1, 10'd1023, 32'hFFFF_FFFF,  32'd0};
    vecs[5] = '{2, 1'b0, 1'b0, 10'd1023, 32'd0,          32'hFFFF_FFFF};
    vecs[6] = '{2, 1'b1, 1'b0, 10'd5,    32'd0,          init_word(5)};
    vecs[7] = '{1, 1'b0, 1'b0, 10'd129,  32'd0,          32'd150};
    vecs[8] = '{0, 1'b1, 1'b1, 10'd0,    32'h1234_5678,  32'd0};
    vecs[9] = '{0, 1'b0, 1'b0, 10'd0,    32'd0,          32'h1234_5678};

    rst_s = '1; if_req_s = '0; d_req_s = '0; d_we_s = '0;
    for (int i = 0; i < NI; i++) begin
      if_addr_s[i] = '0; d_addr_s[i] = '0; d_wdata_s[i] = '0; last_d[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_strobes", 64'({if_gnt_s[i], d_gnt_s[i], if_valid_s[i], d_valid_s[i], mem_en_s[i], mem_we_s[i]}), 64'd0);
      check("rst_buses", 64'(mem_addr_s[i]) | 64'(mem_wdata_s[i]) | 64'(if_rdata_s[i]) | 64'(d_rdata_s[i]), 64'd0);
    end
    rst_s = '0;

    for (int i = 0; i < 10; i++) do_access(vecs[i]);
    check("mem129_written", 64'(lat[1].mem_arr[129]), 64'd150);

    // Simultaneous requests on MEM_LAT=1: data first, fetch on the following RESP arbitration.
    @(negedge clk);
    if_req_s[0] = 1'b1; if_addr_s[0] = 10'd2;
    d_req_s[0] = 1'b1; d_we_s[0] = 1'b0; d_addr_s[0] = 10'd6;
    c = cyc;
    push_exp(0, 1'b1, init_word(6), c + 2);
    last_d[0] = init_word(6);
    wait_gnt(0, got);
    check("sim_d_gnt", 64'(d_gnt_s[0]), 64'd1);
    check("sim_d_gnt_cycle", 64'(cyc), 64'(c + 1));
    check("sim_if_gnt_low", 64'(if_gnt_s[0]), 64'd0);
    d_req_s[0] = 1'b0;
    push_exp(0, 1'b0, init_word(2), c + 4);
    wait_gnt(0, got);
    check("sim_if_gnt", 64'(if_gnt_s[0]), 64'd1);
    check("sim_if_gnt_cycle", 64'(cyc), 64'(c + 3));
    if_req_s[0] = 1'b0;
    wait_drain();

    // Both ports held high for 20 arbitrations.
    @(negedge clk);
    if_req_s[0] = 1'b1; if_addr_s[0] = 10'd3;
    d_req_s[0] = 1'b1; d_we_s[0] = 1'b0; d_addr_s[0] = 10'd6;
    k_model = 0;
    prev = 0;
    for (int a = 0; a < 20; a++) begin
`ifdef MIPS_ARB_STARVE_EN
      exp_if = (k_model == STARVE_MAX);
      k_model = exp_if ? 0 : k_model + 1;
`else
      exp_if = 1'b0;
`endif
      wait_gnt(0, got);
      check("starve_gnt_seen", 64'(got), 64'd1);
      check("starve_if_gnt", 64'(if_gnt_s[0]), 64'(exp_if));
      check("starve_d_gnt", 64'(d_gnt_s[0]), 64'(!exp_if));
      if (a > 0) check("starve_spacing", 64'(cyc - prev), 64'd2);
      prev = cyc;
      push_exp(0, if_gnt_s[0] ? 1'b0 : 1'b1, if_gnt_s[0] ? init_word(3) : init_word(6), cyc + 1);
      if (a == 19) begin
        if_req_s[0] = 1'b0;
        d_req_s[0]  = 1'b0;
      end
    end
    wait_drain();

    // Reset while MEM_LAT=3 instance sits in WAIT.
    @(negedge clk);
    if_req_s[2] = 1'b1; if_addr_s[2] = 10'd4;
    c = cyc;
    wait_gnt(2, got);
    check("rst_seq_gnt_cycle", 64'(cyc), 64'(c + 1));
    if_req_s[2] = 1'b0;
    @(negedge clk);
    rst_s[2] = 1'b1;
    #1;
    check("midrst_strobes", 64'({if_gnt_s[2], d_gnt_s[2], if_valid_s[2], d_valid_s[2], mem_en_s[2], mem_we_s[2]}), 64'd0);
    check("midrst_if_rdata", 64'(if_rdata_s[2]), 64'd0);
    check("midrst_d_rdata", 64'(d_rdata_s[2]), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr_s[2]), 64'd0);
    check("midrst_mem_wdata", 64'(mem_wdata_s[2]), 64'd0);
    @(negedge clk);
    rst_s[2] = 1'b0;
    last_d[2] = '0;
    repeat (6) @(negedge clk);
    do_access('{2, 1'b0, 1'b0, 10'd4, 32'd0, init_word(4)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. It shares one unified instruction/data memory (`Mem`) between two requesters: the IF-stage fetch port and the MEM-stage load/store port. It serialises accesses with a fixed-latency sequencer and returns read data with a one-cycle valid pulse. The MEM-stage port has priority, and an optional anti-starvation counter protects fetch.

## Interface
- `AW`, default 10: word-address width.
- `DW`, default 32: data width.
- `MEM_LAT`, default 1: memory read latency in cycles, from the `mem_en` cycle to the cycle in which `mem_rdata` is valid. Legal values are 1..15.
- `STARVE_MAX`, default 4: consecutive lost arbitrations after which fetch is forced to win.

Ports:
- `clk1` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `if_req` input 1: fetch request. The address must be held stable until grant.
- `if_addr` input AW: fetch word address.
- `if_gnt` output 1: one-cycle pulse when the fetch access is issued.
- `if_valid` output 1: one-cycle pulse when `if_rdata` is valid.
- `if_rdata` output DW: fetched instruction.
- `d_req` input 1: data request.
- `d_we` input 1: 1 for store (SW), 0 for load (LW).
- `d_addr` input AW: data word address.
- `d_wdata` input DW: store data.
- `d_gnt` output 1: one-cycle issue pulse for the data port.
- `d_valid` output 1: one-cycle completion pulse, for both loads and stores.
- `d_rdata` output DW: load data.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: memory write enable.
- `mem_addr` output AW: memory address.
- `mem_wdata` output DW: memory write data.
- `mem_rdata` input DW: memory read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one access is outstanding.
- **Arbitration** is evaluated in IDLE and RESP only. `if_req`/`d_req` levels sampled there count as requests.
  - A request when no pending request wins: go to ISSUE.
  - Nothing pending: RESP goes to IDLE; IDLE stays IDLE.
- **Priority:**
  - Both requesting: data wins, unless the starvation counter equals `STARVE_MAX`, in which case fetch wins.
  - A single requester always wins.
- **Starvation counter** (3 bits, saturating at `STARVE_MAX`):
  - Increments on each arbitration where `if_req` and `d_req` are both high and data wins.
  - Clears when fetch is granted.
- **ISSUE (1 cycle):**
  - `mem_en`=1. `mem_addr`, `mem_we`, `mem_wdata` come from the winner's registered request.
  - The winner's `*_gnt`=1.
  - For fetch, `mem_we` is forced to 0.
- **WAIT:** lasts `MEM_LAT`-1 cycles, counted with a 4-bit down-counter. It is skipped when `MEM_LAT`=1.
- **RESP (1 cycle):**
  - `mem_rdata`, sampled at the end of the last WAIT/ISSUE cycle, appears on the winner's `*_rdata`.
  - The winner's `*_valid`=1.
  - For stores, `d_valid`=1 and `d_rdata` holds its previous value.
- After `*_gnt`, the requester deasserts `*_req` or presents the next request. The level seen in RESP is treated as a new request.
- The `*_rdata` outputs hold their value until the next RESP for that port.
- No address range or alignment checking is done. `AW` bits pass through unchanged.

## Timing
- **Reset values:**
  - `if_gnt`, `d_gnt`, `if_valid`, `d_valid`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - State is IDLE and the starvation counter is 0.
- **Latency:** request seen in IDLE at cycle N → grant and `mem_en` in cycle N+1 → valid in cycle N+1+`MEM_LAT`.
- **Throughput:** back-to-back requests complete one access per `MEM_LAT`+1 cycles, because RESP overlaps the next arbitration.
- **Reset mid-operation:**
  - All outputs clear immediately and no valid pulse is produced for the aborted access.
  - A write already strobed into memory is not undone.
- A `*_req` deasserted before grant is simply dropped. No error is reported.

## Configuration
- `MIPS_ARB_STARVE_EN` defined: the starvation counter is present and fetch wins on reaching `STARVE_MAX`.
- `MIPS_ARB_STARVE_EN` undefined: strict data priority with no counter logic. Fetch can starve indefinitely under continuous `d_req`.

## Test plan
- **Fetch read**, `MEM_LAT`=1, Mem[0]=32'h28010080: `if_req`, `if_addr`=0 in cycle 0 → `if_gnt` and `mem_en` in cycle 1, `if_valid` with `if_rdata`=32'h28010080 in cycle 2.
- **Store then load**, `MEM_LAT`=2: SW 150 to addr 129, then LW addr 129.
  - SW → `d_valid` 3 cycles after request, Mem[129]=150.
  - LW → `d_rdata`=150.
- **Simultaneous single requests:** `if_req`=`d_req`=1 in the same IDLE cycle → `d_gnt` first. `if_gnt` is issued in the following RESP arbitration and the starvation counter returns to 0.
- **Starvation**, macro defined, `STARVE_MAX`=4, `d_req` and `if_req` held high → four data grants, then `if_gnt` on the 5th arbitration, then data again.
- **Same stimulus, macro undefined** → no `if_gnt` over 20 arbitrations.
- **Reset mid-access:** `rst` pulse during WAIT (`MEM_LAT`=3) → no `*_valid` pulse, all outputs 0, and a new `if_req` after reset completes normally with latency `MEM_LAT`+1.
